// File: rtl/alu_if.sv
// Operand/result bundle for the execute-stage ALU.
// The master drives operands and opcode; the slave (the ALU) returns the registered result and flags.
interface alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, data0, data1, opcode,
        input  out, out_valid, zero, negative, carry, overflow
    );

    modport slave (
        input  in_valid, data0, data1, opcode,
        output out, out_valid, zero, negative, carry, overflow
    );
endinterface

// File: rtl/alu.sv
// Registered integer ALU for the execute stage: one result per accepted operation,
// available one clock after in_valid. Optional macro ALU_MUL_EN adds an unsigned
// low-half multiply on opcode 0111; without it that opcode yields 0.
module alu #(
    parameter int WIDTH = 32
) (
    input logic  clk,
    input logic  rst,
    alu_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_ROL  = 4'b1100;
    localparam logic [3:0] OP_ROR  = 4'b1101;
    localparam logic [3:0] OP_SLTU = 4'b1110;
    localparam logic [3:0] OP_PASS = 4'b1111;

    // Rotate left; a zero amount leaves the operand unchanged (a >> WIDTH is 0).
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] a, input logic [SH_W-1:0] s);
        return (a << s) | (a >> (WIDTH - int'(s)));
    endfunction

    // Rotate right; mirror of rotl.
    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] a, input logic [SH_W-1:0] s);
        return (a >> s) | (a << (WIDTH - int'(s)));
    endfunction

    // Signed overflow of a+b (sub=0) or a-b (sub=1) given the modulo result r.
    function automatic logic ovf(input logic sa, input logic sb, input logic sr, input logic sub);
        return sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    endfunction

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic        [SH_W-1:0]  sh;
    logic        [WIDTH:0]   sum_p0;
    logic        [WIDTH:0]   diff_p0;
    logic                    borrow_p0;
    logic        [WIDTH-1:0] res_p0;
    logic                    carry_p0;
    logic                    ovf_p0;
    logic        [WIDTH-1:0] prod_p0;

    logic        [WIDTH-1:0] out_p1;
    logic                    vld_p1;
    logic                    zero_p1;
    logic                    neg_p1;
    logic                    carry_p1;
    logic                    ovf_p1;

    assign a_s       = bus.data0;
    assign b_s       = bus.data1;
    assign sh        = bus.data1[SH_W-1:0];
    assign sum_p0    = {1'b0, bus.data0} + {1'b0, bus.data1};
    assign diff_p0   = {1'b0, bus.data0} - {1'b0, bus.data1};
    assign borrow_p0 = diff_p0[WIDTH];

`ifdef ALU_MUL_EN
    assign prod_p0 = bus.data0 * bus.data1;
`else
    assign prod_p0 = '0;
`endif

    // Stage p0: combinational result and arithmetic flags from the current operands.
    always_comb begin
        res_p0   = '0;
        carry_p0 = 1'b0;
        ovf_p0   = 1'b0;
        unique case (bus.opcode)
            OP_ADD: begin
                res_p0   = sum_p0[WIDTH-1:0];
                carry_p0 = sum_p0[WIDTH];
                ovf_p0   = ovf(a_s[WIDTH-1], b_s[WIDTH-1], sum_p0[WIDTH-1], 1'b0);
            end
            OP_SUB: begin
                res_p0   = diff_p0[WIDTH-1:0];
                carry_p0 = borrow_p0;
                ovf_p0   = ovf(a_s[WIDTH-1], b_s[WIDTH-1], diff_p0[WIDTH-1], 1'b1);
            end
            OP_AND:  res_p0 = bus.data0 & bus.data1;
            OP_OR:   res_p0 = bus.data0 | bus.data1;
            OP_XOR:  res_p0 = bus.data0 ^ bus.data1;
            OP_NAND: res_p0 = ~(bus.data0 & bus.data1);
            OP_NOR:  res_p0 = ~(bus.data0 | bus.data1);
            OP_MUL:  res_p0 = prod_p0;
            OP_SLT: begin
                res_p0   = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
                carry_p0 = borrow_p0;
            end
            OP_SLL:  res_p0 = bus.data0 << sh;
            OP_SRL:  res_p0 = bus.data0 >> sh;
            OP_SRA:  res_p0 = a_s >>> sh;
            OP_ROL:  res_p0 = rotl(bus.data0, sh);
            OP_ROR:  res_p0 = rotr(bus.data0, sh);
            OP_SLTU: begin
                res_p0   = {{(WIDTH-1){1'b0}}, borrow_p0};
                carry_p0 = borrow_p0;
            end
            OP_PASS: res_p0 = bus.data0;
            default: res_p0 = '0;
        endcase
    end

    // Stage p1: capture result and flags on valid input; reset forces the idle/zero state.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            out_p1   <= '0;
            zero_p1  <= 1'b1;
            neg_p1   <= 1'b0;
            carry_p1 <= 1'b0;
            ovf_p1   <= 1'b0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                out_p1   <= res_p0;
                zero_p1  <= (res_p0 == '0);
                neg_p1   <= res_p0[WIDTH-1];
                carry_p1 <= carry_p0;
                ovf_p1   <= ovf_p0;
            end
        end
    end

    assign bus.out       = out_p1;
    assign bus.out_valid = vld_p1;
    assign bus.zero      = zero_p1;
    assign bus.negative  = neg_p1;
    assign bus.carry     = carry_p1;
    assign bus.overflow  = ovf_p1;
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU; expected values are hand-computed.
module tb_alu;
    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    alu_if #(.WIDTH(32)) bus ();

    alu #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Flags packed as {out_valid, zero, negative, carry, overflow}.
    function automatic logic [31:0] flags();
        return {27'd0, bus.out_valid, bus.zero, bus.negative, bus.carry, bus.overflow};
    endfunction

    // Present one valid operation, step one edge, then check result and flags.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_out, input logic [4:0] exp_fl);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.data0    = a;
        bus.data1    = b;
        @(posedge clk);
        #1;
        check({tag, ".out"}, bus.out, exp_out);
        check({tag, ".flags"}, flags(), {27'd0, exp_fl});
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.opcode   = 4'd0;
        bus.data0    = '0;
        bus.data1    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.out", bus.out, 32'd0);
        check("reset.flags", flags(), 32'b01000);
        rst = 1'b0;

        // Back-to-back valid operations: one result per cycle.
        run_op("add",       4'b0000, 32'd35,         32'd12,         32'd47,         5'b10000);
        run_op("sub_eq",    4'b0001, 32'd5,          32'd5,          32'd0,          5'b11000);
        run_op("sub_neg",   4'b0001, 32'd12,         32'd40,         32'hFFFFFFE4,   5'b10110);
        run_op("and",       4'b0010, 32'd30,         32'd20,         32'd20,         5'b10000);
        run_op("or",        4'b0011, 32'd30,         32'd20,         32'd30,         5'b10000);
        run_op("add_ovf",   4'b0000, 32'h7FFFFFFF,   32'd1,          32'h80000000,   5'b10101);
        run_op("add_carry", 4'b0000, 32'hFFFFFFFF,   32'd1,          32'd0,          5'b11010);
        run_op("sub_ovf",   4'b0001, 32'h80000000,   32'd1,          32'h7FFFFFFF,   5'b10001);
        run_op("xor",       4'b0100, 32'h0000F0F0,   32'h0000FF00,   32'h00000FF0,   5'b10000);
        run_op("nand",      4'b0101, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          5'b11000);
        run_op("nor",       4'b0110, 32'd0,          32'd0,          32'hFFFFFFFF,   5'b10100);
        run_op("sll",       4'b1001, 32'd1,          32'd5,          32'd32,         5'b10000);
        run_op("srl",       4'b1010, 32'd20,         32'd10,         32'd0,          5'b11000);
        run_op("sra",       4'b1011, 32'h80000000,   32'd4,          32'hF8000000,   5'b10100);
        run_op("sra31",     4'b1011, 32'h80000000,   32'd31,         32'hFFFFFFFF,   5'b10100);
        run_op("rol",       4'b1100, 32'd15,         32'd3,          32'd120,        5'b10000);
        run_op("ror",       4'b1101, 32'd23,         32'd2,          32'hC0000005,   5'b10100);
        run_op("rol_sh0",   4'b1100, 32'h12345678,   32'd32,         32'h12345678,   5'b10000);
        run_op("ror_sh0",   4'b1101, 32'h12345678,   32'd0,          32'h12345678,   5'b10000);
        run_op("slt",       4'b1000, 32'hFFFFFFFF,   32'd1,          32'd1,          5'b10000);
        run_op("sltu_f",    4'b1110, 32'hFFFFFFFF,   32'd1,          32'd0,          5'b11000);
        run_op("sltu_t",    4'b1110, 32'd1,          32'hFFFFFFFF,   32'd1,          5'b10010);
        run_op("pass",      4'b1111, 32'hDEADBEEF,   32'd7,          32'hDEADBEEF,   5'b10100);
`ifdef ALU_MUL_EN
        run_op("mul",       4'b0111, 32'd35,         32'd4,          32'd140,        5'b10000);
`else
        run_op("mul",       4'b0111, 32'd35,         32'd4,          32'd0,          5'b11000);
`endif

        // Idle cycle: out_valid drops, result and flags hold.
        run_op("pre_idle",  4'b0000, 32'd100,        32'd23,         32'd123,        5'b10000);
        bus.in_valid = 1'b0;
        bus.data0    = 32'd9;
        @(posedge clk);
        #1;
        check("idle.out", bus.out, 32'd123);
        check("idle.flags", flags(), 32'b00000);

        // Reset wins over a simultaneous valid operation.
        bus.in_valid = 1'b1;
        bus.opcode   = 4'b0000;
        bus.data0    = 32'd1;
        bus.data1    = 32'd1;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        check("rst_vld.out", bus.out, 32'd0);
        check("rst_vld.flags", flags(), 32'b01000);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst.out", bus.out, 32'd0);
        check("post_rst.flags", flags(), 32'b01000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
